// File: rtl/renas_mem_arbiter_pkg.sv
// Shared types and constants for the renas main-memory arbiter.
//   - SRAM geometry (MEM_BASE, MEM_LINE, ADDR_W) and data width
//   - AHB-lite transfer/response encodings and master/slave bundles
//   - Per-port FSM state type and pending-request record
//   - calc_be(): AHB size/offset to SRAM byte-enable decode
package renas_mem_arbiter_pkg;

  localparam int unsigned DATA_LENGTH = 32;

  localparam logic [31:0] MEM_BASE = 32'h0000_0400;
  localparam int unsigned MEM_LINE = 16384;
  localparam int unsigned ADDR_W   = $clog2(MEM_LINE);

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef struct packed {
    logic [31:0]            haddr;
    logic [1:0]             htrans;
    logic                   hwrite;
    logic [2:0]             hsize;
    logic [DATA_LENGTH-1:0] hwdata;
  } mas_send_type;

  typedef struct packed {
    logic [DATA_LENGTH-1:0] hrdata;
    logic                   hreadyout;
    logic                   hresp;
  } slv_send_type;

  typedef enum logic [2:0] {
    P_IDLE,
    P_WAIT,
    P_ACC,
    P_ERR1,
    P_ERR2
  } port_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] word;
    logic [1:0]        byte_off;
    logic [2:0]        hsize;
    logic              hwrite;
    logic              range_err;
  } pend_req_t;

  // Byte lanes touched by a write of the given size at the given byte offset.
  function automatic logic [3:0] calc_be(input logic [1:0] off, input logic [2:0] hsize);
    logic [3:0] be;
    case (hsize)
      3'd0:    be = 4'b0001 << off;
      3'd1:    be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/renas_mem_arbiter_port_fsm.sv
// One AHB slave port of the shared SRAM: address-phase capture, range check,
// pending request register, wait/error FSM and response generation.
// Ports:
//   clk_l2, rst_n   clock, asynchronous active-low reset
//   i_hsel, i_mas   AHB select and master bundle
//   i_grant         arbiter grant (valid only while o_wait is high)
//   i_sram_rdata    SRAM read data, valid the cycle after the grant
//   o_slv           AHB response bundle
//   o_wait          request pending for the SRAM
//   o_word, o_be,
//   o_hwrite,
//   o_wdata         SRAM command fields for this port
module renas_mem_arbiter_port_fsm
  import renas_mem_arbiter_pkg::*;
(
  input  logic                   clk_l2,
  input  logic                   rst_n,
  input  logic                   i_hsel,
  input  mas_send_type           i_mas,
  input  logic                   i_grant,
  input  logic [DATA_LENGTH-1:0] i_sram_rdata,
  output slv_send_type           o_slv,
  output logic                   o_wait,
  output logic [ADDR_W-1:0]      o_word,
  output logic [3:0]             o_be,
  output logic                   o_hwrite,
  output logic [DATA_LENGTH-1:0] o_wdata
);

  port_state_e r_state, w_state_next;
  pend_req_t   r_req;
  pend_req_t   w_new_req;

  logic        w_hreadyout;
  logic        w_active;
  logic        w_accept;
  logic [31:0] w_offset;
  logic        w_range_err;

  assign w_hreadyout = !((r_state == P_WAIT) || (r_state == P_ERR1));
  assign w_active    = (i_mas.htrans == HTRANS_NONSEQ) || (i_mas.htrans == HTRANS_SEQ);
  assign w_accept    = i_hsel & w_active & w_hreadyout;

  // MEM_BASE is word aligned, so the low offset bits equal haddr[1:0].
  assign w_offset    = i_mas.haddr - MEM_BASE;
  assign w_range_err = (i_mas.haddr < MEM_BASE) ||
                       (w_offset[31:2] >= 30'(MEM_LINE)) ||
                       (i_mas.hsize > 3'd2);

  always_comb begin
    w_new_req           = '0;
    w_new_req.word      = w_offset[ADDR_W+1:2];
    w_new_req.byte_off  = w_offset[1:0];
    w_new_req.hsize     = i_mas.hsize;
    w_new_req.hwrite    = i_mas.hwrite;
    w_new_req.range_err = w_range_err;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      P_IDLE, P_ACC, P_ERR2: begin
        if (w_accept) begin
          w_state_next = w_range_err ? P_ERR1 : P_WAIT;
        end else begin
          w_state_next = P_IDLE;
        end
      end
      P_WAIT:  if (i_grant) w_state_next = P_ACC;
      P_ERR1:  w_state_next = P_ERR2;
      default: w_state_next = P_IDLE;
    endcase
  end

  always_ff @(posedge clk_l2 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= P_IDLE;
      r_req   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) r_req <= w_new_req;
    end
  end

  always_comb begin
    o_slv           = '0;
    o_slv.hreadyout = w_hreadyout;
    o_slv.hresp     = HRESP_OKAY;
    if ((r_state == P_ERR1) || (r_state == P_ERR2)) o_slv.hresp = HRESP_ERROR;
    if ((r_state == P_ACC) && !r_req.hwrite) o_slv.hrdata = i_sram_rdata;
  end

  // A faulting request never reaches P_WAIT; the gate keeps it off the SRAM regardless.
  assign o_wait   = (r_state == P_WAIT) && !r_req.range_err;
  assign o_word   = r_req.word;
  assign o_hwrite = r_req.hwrite;
  assign o_be     = r_req.hwrite ? calc_be(r_req.byte_off, r_req.hsize) : 4'b1111;
  // The master holds hwdata for the whole data phase, including wait states.
  assign o_wdata  = i_mas.hwdata;

endmodule

// File: rtl/renas_mem_arbiter.sv
// Shares one single-port synchronous SRAM between the I-AHB and D-AHB slave
// ports. Each port runs its own FSM; this level holds the round-robin
// arbiter, the last_grant register and the SRAM command mux.
// Ports:
//   clk_l2, rst_n           clock, asynchronous active-low reset
//   imem_hsel/in/out        I-port AHB select, master bundle, response
//   dmem_hsel/in/out        D-port AHB select, master bundle, response
//   sram_addr/wdata/be/wen  SRAM command (combinational, in the grant cycle)
//   sram_rdata              SRAM read data, one cycle after the command
module renas_mem_arbiter
  import renas_mem_arbiter_pkg::*;
(
  input  logic                   clk_l2,
  input  logic                   rst_n,
  input  logic                   imem_hsel,
  input  mas_send_type           imem_in,
  output slv_send_type           imem_out,
  input  logic                   dmem_hsel,
  input  mas_send_type           dmem_in,
  output slv_send_type           dmem_out,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [DATA_LENGTH-1:0] sram_wdata,
  output logic [3:0]             sram_be,
  output logic                   sram_wen,
  input  logic [DATA_LENGTH-1:0] sram_rdata
);

  logic                   w_i_wait, w_d_wait;
  logic                   w_grant_i, w_grant_d;
  logic [ADDR_W-1:0]      w_i_word, w_d_word;
  logic [3:0]             w_i_be, w_d_be;
  logic                   w_i_hwrite, w_d_hwrite;
  logic [DATA_LENGTH-1:0] w_i_wdata, w_d_wdata;
  // 1: D was granted last, 0: I was granted last.
  logic                   r_last_grant_d;

  renas_mem_arbiter_port_fsm u_iport (
    .clk_l2       (clk_l2),
    .rst_n        (rst_n),
    .i_hsel       (imem_hsel),
    .i_mas        (imem_in),
    .i_grant      (w_grant_i),
    .i_sram_rdata (sram_rdata),
    .o_slv        (imem_out),
    .o_wait       (w_i_wait),
    .o_word       (w_i_word),
    .o_be         (w_i_be),
    .o_hwrite     (w_i_hwrite),
    .o_wdata      (w_i_wdata)
  );

  renas_mem_arbiter_port_fsm u_dport (
    .clk_l2       (clk_l2),
    .rst_n        (rst_n),
    .i_hsel       (dmem_hsel),
    .i_mas        (dmem_in),
    .i_grant      (w_grant_d),
    .i_sram_rdata (sram_rdata),
    .o_slv        (dmem_out),
    .o_wait       (w_d_wait),
    .o_word       (w_d_word),
    .o_be         (w_d_be),
    .o_hwrite     (w_d_hwrite),
    .o_wdata      (w_d_wdata)
  );

  // On a conflict the port that did not win last time goes first.
  assign w_grant_d = w_d_wait & (~w_i_wait | ~r_last_grant_d);
  assign w_grant_i = w_i_wait & ~w_grant_d;

  always_ff @(posedge clk_l2 or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant_d <= 1'b0;
    end else if (w_grant_d) begin
      r_last_grant_d <= 1'b1;
    end else if (w_grant_i) begin
      r_last_grant_d <= 1'b0;
    end
  end

  always_comb begin
    sram_addr  = '0;
    sram_wdata = '0;
    sram_be    = '0;
    sram_wen   = 1'b0;
    if (w_grant_d) begin
      sram_addr = w_d_word;
      sram_be   = w_d_be;
      if (w_d_hwrite) begin
        sram_wen   = 1'b1;
        sram_wdata = w_d_wdata;
      end
    end else if (w_grant_i) begin
      sram_addr = w_i_word;
      sram_be   = w_i_be;
      if (w_i_hwrite) begin
        sram_wen   = 1'b1;
        sram_wdata = w_i_wdata;
      end
    end
  end

endmodule

// File: tb/tb_renas_mem_arbiter.sv
module tb_renas_mem_arbiter;
  import renas_mem_arbiter_pkg::*;

  logic                   clk_l2;
  logic                   rst_n;
  logic                   imem_hsel, dmem_hsel;
  mas_send_type           imem_in, dmem_in;
  slv_send_type           imem_out, dmem_out;
  logic [ADDR_W-1:0]      sram_addr;
  logic [DATA_LENGTH-1:0] sram_wdata;
  logic [3:0]             sram_be;
  logic                   sram_wen;
  logic [DATA_LENGTH-1:0] sram_rdata;
  logic                   mem_load;

  logic [DATA_LENGTH-1:0] mem [MEM_LINE];

  int n_checks = 0;
  int n_errs   = 0;

  renas_mem_arbiter dut (
    .clk_l2     (clk_l2),
    .rst_n      (rst_n),
    .imem_hsel  (imem_hsel),
    .imem_in    (imem_in),
    .imem_out   (imem_out),
    .dmem_hsel  (dmem_hsel),
    .dmem_in    (dmem_in),
    .dmem_out   (dmem_out),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_be    (sram_be),
    .sram_wen   (sram_wen),
    .sram_rdata (sram_rdata)
  );

  initial begin
    clk_l2 = 1'b0;
    forever #5 clk_l2 = ~clk_l2;
  end

  // SRAM model: byte-enabled write, registered read.
  always @(posedge clk_l2) begin
    if (mem_load) begin
      mem[0]     <= 32'hDEAD_BEEF;
      mem[256]   <= 32'h1234_5678;
      mem[257]   <= 32'h0000_0000;
      mem[16383] <= 32'hCAFE_F00D;
    end else if (sram_wen) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
    sram_rdata <= mem[sram_addr];
  end

  typedef struct {
    logic        pd;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_wen;
    int          exp_acc;
    logic [3:0]  exp_be;
    logic [13:0] exp_sa;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic pd, input logic [31:0] a, input logic w,
                              input logic [2:0] s, input logic [31:0] wd,
                              input logic [31:0] rd, input logic e, input int wen,
                              input int acc, input logic [3:0] be, input logic [13:0] sa);
    vec_t v;
    v.pd = pd; v.addr = a; v.wr = w; v.size = s; v.wdata = wd; v.exp_rdata = rd;
    v.exp_err = e; v.exp_wen = wen; v.exp_acc = acc; v.exp_be = be; v.exp_sa = sa;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_addr(input logic pd, input logic [31:0] a, input logic w,
                            input logic [2:0] s);
    if (pd) begin
      dmem_hsel = 1'b1; dmem_in.haddr = a; dmem_in.htrans = HTRANS_NONSEQ;
      dmem_in.hwrite = w; dmem_in.hsize = s;
    end else begin
      imem_hsel = 1'b1; imem_in.haddr = a; imem_in.htrans = HTRANS_NONSEQ;
      imem_in.hwrite = w; imem_in.hsize = s;
    end
  endtask

  task automatic end_addr(input logic pd, input logic [31:0] wd);
    if (pd) begin
      dmem_hsel = 1'b0; dmem_in.htrans = HTRANS_IDLE; dmem_in.hwdata = wd;
    end else begin
      imem_hsel = 1'b0; imem_in.htrans = HTRANS_IDLE; imem_in.hwdata = wd;
    end
  endtask

  // One uncontended transfer; reports what was seen on the port and SRAM side.
  task automatic do_xfer(input logic pd, input logic [31:0] a, input logic w,
                         input logic [2:0] s, input logic [31:0] wd,
                         output logic [31:0] rdata, output int waits, output logic err_any,
                         output logic err_all, output int wen_cnt, output int acc_cnt,
                         output logic [3:0] be_seen, output logic [13:0] sa_seen);
    slv_send_type rsp;
    logic done;
    @(posedge clk_l2); #1;
    drive_addr(pd, a, w, s);
    @(posedge clk_l2); #1;
    end_addr(pd, wd);
    rdata = '0; waits = 0; err_any = 0; err_all = 1; wen_cnt = 0; acc_cnt = 0;
    be_seen = '0; sa_seen = '0; done = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk_l2);
      if (sram_wen) wen_cnt++;
      if (sram_be != 4'b0) begin
        acc_cnt++; be_seen = sram_be; sa_seen = sram_addr;
      end
      rsp = pd ? dmem_out : imem_out;
      if (rsp.hresp == HRESP_ERROR) err_any = 1; else err_all = 0;
      if (rsp.hreadyout) begin
        done = 1; rdata = rsp.hrdata;
      end else begin
        waits++;
      end
      if (!done) @(posedge clk_l2);
    end
    chk("xfer_completes", 32'(done), 32'd1);
  endtask

  logic [31:0] rd;
  int          waits, wen_cnt, acc_cnt;
  logic        err_any, err_all;
  logic [3:0]  be_seen;
  logic [13:0] sa_seen;

  initial begin
    int bad;
    int i_w, d_w, acc_n;
    logic i_done, d_done;
    logic [31:0] i_rd, d_rd;
    logic [13:0] acc_list[4];

    vecs[0]  = mk(0, 32'h400,   0, 2, 32'h0,         32'hDEADBEEF, 0, 0, 1, 4'hF, 14'h000);
    vecs[1]  = mk(1, 32'h803,   1, 0, 32'hAB000000,  32'h0,        0, 1, 1, 4'h8, 14'h100);
    vecs[2]  = mk(1, 32'h800,   0, 2, 32'h0,         32'hAB345678, 0, 0, 1, 4'hF, 14'h100);
    vecs[3]  = mk(1, 32'h806,   1, 1, 32'h11220000,  32'h0,        0, 1, 1, 4'hC, 14'h101);
    vecs[4]  = mk(0, 32'h804,   0, 2, 32'h0,         32'h11220000, 0, 0, 1, 4'hF, 14'h101);
    vecs[5]  = mk(1, 32'h300,   0, 2, 32'h0,         32'h0,        1, 0, 0, 4'h0, 14'h000);
    vecs[6]  = mk(1, 32'h10400, 0, 2, 32'h0,         32'h0,        1, 0, 0, 4'h0, 14'h000);
    vecs[7]  = mk(1, 32'h103FC, 0, 2, 32'h0,         32'hCAFEF00D, 0, 0, 1, 4'hF, 14'h3FFF);
    vecs[8]  = mk(0, 32'h103FC, 1, 2, 32'h0BADC0DE,  32'h0,        0, 1, 1, 4'hF, 14'h3FFF);
    vecs[9]  = mk(1, 32'h103FC, 0, 2, 32'h0,         32'h0BADC0DE, 0, 0, 1, 4'hF, 14'h3FFF);
    vecs[10] = mk(0, 32'h400,   0, 3, 32'h0,         32'h0,        1, 0, 0, 4'h0, 14'h000);
    vecs[11] = mk(0, 32'h401,   1, 0, 32'h00005500,  32'h0,        0, 1, 1, 4'h2, 14'h000);
    vecs[12] = mk(0, 32'h400,   0, 2, 32'h0,         32'hDEAD55EF, 0, 0, 1, 4'hF, 14'h000);
    vecs[13] = mk(1, 32'h3FF,   1, 0, 32'h000000FF,  32'h0,        1, 0, 0, 4'h0, 14'h000);

    imem_in = '0; dmem_in = '0; imem_hsel = 0; dmem_hsel = 0;
    rst_n = 1'b0; mem_load = 1'b1;
    repeat (3) @(posedge clk_l2);
    #1 mem_load = 1'b0;
    #2 rst_n = 1'b1;

    // Reset state
    @(negedge clk_l2);
    chk("rst_i_hreadyout", 32'(imem_out.hreadyout), 32'd1);
    chk("rst_d_hreadyout", 32'(dmem_out.hreadyout), 32'd1);
    chk("rst_i_hresp",     32'(imem_out.hresp),     32'(HRESP_OKAY));
    chk("rst_d_hresp",     32'(dmem_out.hresp),     32'(HRESP_OKAY));
    chk("rst_i_hrdata",    imem_out.hrdata,         32'h0);
    chk("rst_d_hrdata",    dmem_out.hrdata,         32'h0);
    chk("rst_sram_wen",    32'(sram_wen),           32'd0);
    chk("rst_sram_addr",   32'(sram_addr),          32'd0);
    chk("rst_sram_be",     32'(sram_be),            32'd0);
    chk("rst_sram_wdata",  sram_wdata,              32'h0);

    // IDLE/BUSY transfers are ignored with a zero-wait OKAY.
    imem_hsel = 1; imem_in.htrans = HTRANS_IDLE;
    dmem_hsel = 1; dmem_in.htrans = HTRANS_BUSY;
    bad = 0;
    repeat (5) begin
      @(negedge clk_l2);
      if (sram_wen || sram_be != 0 || !imem_out.hreadyout || !dmem_out.hreadyout) bad++;
    end
    chk("idle_busy_ignored", 32'(bad), 32'd0);
    imem_hsel = 0; dmem_hsel = 0; dmem_in.htrans = HTRANS_IDLE;

    // Table of single uncontended transfers
    for (int v = 0; v < 14; v++) begin
      do_xfer(vecs[v].pd, vecs[v].addr, vecs[v].wr, vecs[v].size, vecs[v].wdata,
              rd, waits, err_any, err_all, wen_cnt, acc_cnt, be_seen, sa_seen);
      chk($sformatf("v%0d_rdata", v),   rd,                     vecs[v].exp_rdata);
      chk($sformatf("v%0d_waits", v),   32'(waits),             32'd1);
      chk($sformatf("v%0d_err_any", v), 32'(err_any),           32'(vecs[v].exp_err));
      chk($sformatf("v%0d_err_all", v), 32'(err_all),           32'(vecs[v].exp_err));
      chk($sformatf("v%0d_wen", v),     32'(wen_cnt),           32'(vecs[v].exp_wen));
      chk($sformatf("v%0d_acc", v),     32'(acc_cnt),           32'(vecs[v].exp_acc));
      chk($sformatf("v%0d_be", v),      32'(be_seen),           32'(vecs[v].exp_be));
      chk($sformatf("v%0d_saddr", v),   32'(sa_seen),           32'(vecs[v].exp_sa));
    end

    // Simultaneous I and D reads, three rounds: D wins each round, I follows.
    for (int r = 0; r < 3; r++) begin
      @(posedge clk_l2); #1;
      drive_addr(0, 32'h400, 0, 2);
      drive_addr(1, 32'h800, 0, 2);
      @(posedge clk_l2); #1;
      end_addr(0, 32'h0);
      end_addr(1, 32'h0);
      i_w = 0; d_w = 0; acc_n = 0; i_done = 0; d_done = 0; i_rd = '0; d_rd = '0;
      for (int c = 0; c < 10 && !(i_done && d_done); c++) begin
        @(negedge clk_l2);
        if (sram_be != 0 && acc_n < 4) begin
          acc_list[acc_n] = sram_addr; acc_n++;
        end
        if (!d_done) begin
          if (dmem_out.hreadyout) begin d_done = 1; d_rd = dmem_out.hrdata; end
          else d_w++;
        end
        if (!i_done) begin
          if (imem_out.hreadyout) begin i_done = 1; i_rd = imem_out.hrdata; end
          else i_w++;
        end
        if (!(i_done && d_done)) @(posedge clk_l2);
      end
      chk($sformatf("cf%0d_done", r),   32'(i_done && d_done), 32'd1);
      chk($sformatf("cf%0d_d_waits", r), 32'(d_w),  32'd1);
      chk($sformatf("cf%0d_i_waits", r), 32'(i_w),  32'd2);
      chk($sformatf("cf%0d_d_rdata", r), d_rd,      32'hAB345678);
      chk($sformatf("cf%0d_i_rdata", r), i_rd,      32'hDEAD55EF);
      chk($sformatf("cf%0d_acc_n", r),  32'(acc_n), 32'd2);
      chk($sformatf("cf%0d_first", r),  32'(acc_list[0]), 32'h100);
      chk($sformatf("cf%0d_second", r), 32'(acc_list[1]), 32'h000);
    end

    // Lone D access leaves last_grant at D, so I wins the next conflict.
    do_xfer(1, 32'h800, 0, 2, 32'h0, rd, waits, err_any, err_all, wen_cnt, acc_cnt,
            be_seen, sa_seen);
    chk("pre_rst_d_rdata", rd, 32'hAB345678);

    // Reset while the D write is stuck in P_WAIT behind an I read.
    @(posedge clk_l2); #1;
    drive_addr(0, 32'h400, 0, 2);
    drive_addr(1, 32'h800, 1, 2);
    @(posedge clk_l2); #1;
    end_addr(0, 32'h0);
    end_addr(1, 32'hFFFF_FFFF);
    @(negedge clk_l2);
    chk("mid_d_waiting",  32'(dmem_out.hreadyout), 32'd0);
    chk("mid_i_granted",  32'(sram_be),            32'hF);
    chk("mid_wen_low",    32'(sram_wen),           32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_d_hreadyout", 32'(dmem_out.hreadyout), 32'd1);
    chk("arst_i_hreadyout", 32'(imem_out.hreadyout), 32'd1);
    chk("arst_d_hresp",     32'(dmem_out.hresp),     32'(HRESP_OKAY));
    chk("arst_sram_wen",    32'(sram_wen),           32'd0);
    chk("arst_sram_be",     32'(sram_be),            32'd0);
    chk("arst_sram_addr",   32'(sram_addr),          32'd0);
    chk("arst_sram_wdata",  sram_wdata,              32'h0);
    repeat (2) @(posedge clk_l2);
    #3 rst_n = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk_l2);
      if (sram_wen) bad++;
    end
    chk("post_rst_no_wen", 32'(bad), 32'd0);
    do_xfer(1, 32'h800, 0, 2, 32'h0, rd, waits, err_any, err_all, wen_cnt, acc_cnt,
            be_seen, sa_seen);
    chk("post_rst_word_kept", rd, 32'hAB345678);
    chk("post_rst_waits", 32'(waits), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
